// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder (+ ripple_carry 4-bit adder)
// Purpose  : Wide add done one nibble per cycle through a single 4-bit adder.
// Revision : 1.0
// ============================================================================

module ripple_carry (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[4];
endmodule

module nibble_serial_adder #(
    parameter int N_NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*N_NIBBLES-1:0] a,
    input  logic [4*N_NIBBLES-1:0] b,
    input  logic                   cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*N_NIBBLES-1:0] sum,
    output logic                   cout,
    output logic                   busy
);
    localparam int W     = 4 * N_NIBBLES;
    localparam int IDX_W = (N_NIBBLES > 1) ? $clog2(N_NIBBLES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IDX_W-1:0] c_LAST = IDX_W'(N_NIBBLES - 1);

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_sum;
    logic             r_carry;
    logic             r_cout;

    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [3:0]       w_nib_sum;
    logic             w_nib_cout;

    // Nibble select feeds the adder directly; no pipeline stage in between.
    always_comb begin
        w_a_nib = '0;
        w_b_nib = '0;
        for (int i = 0; i < N_NIBBLES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_a_nib = r_a[4*i +: 4];
                w_b_nib = r_b[4*i +: 4];
            end
        end
    end

    ripple_carry u_adder (
        .a    (w_a_nib),
        .b    (w_b_nib),
        .cin  (r_carry),
        .sum  (w_nib_sum),
        .cout (w_nib_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_state <= S_ADD;
                    end
                end
                S_ADD: begin
                    for (int i = 0; i < N_NIBBLES; i++) begin
                        if (r_idx == IDX_W'(i)) begin
                            r_sum[4*i +: 4] <= w_nib_sum;
                        end
                    end
                    r_carry <= w_nib_cout;
                    if (r_idx == c_LAST) begin
                        r_cout  <= w_nib_cout;
                        r_idx   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // in_ready drops with rst itself so nothing is accepted during reset.
    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign sum       = r_sum;
    assign cout      = r_cout;
endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_adder
// Purpose  : Directed and random checks of nibble_serial_adder (N=4 and N=1).
// Revision : 1.0
// ============================================================================

module tb_nibble_serial_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
    logic [15:0] a, b, sum;

    logic        in_valid1, in_ready1, out_valid1, out_ready1, cin1, cout1, busy1;
    logic [3:0]  a1, b1, sum1;

    int n_vec = 0;
    int n_err = 0;

    nibble_serial_adder #(.N_NIBBLES(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    nibble_serial_adder #(.N_NIBBLES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer addition at wider width.
    function automatic logic [16:0] ref4(input logic [15:0] x, input logic [15:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {16'd0, c};
    endfunction

    task automatic start4(input logic [15:0] x, input logic [15:0] y, input logic c);
        a = x; b = y; cin = c; in_valid = 1'b1;
        check("accept_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    endtask

    task automatic wait4(input string tag);
        int lat = 0;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        while (!out_valid && lat < 40) begin
            check({tag, "_in_ready_lo"}, {31'd0, in_ready}, 32'd0);
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, 32'd4);
    endtask

    task automatic take4(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_ov_clr"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic add4(input string tag, input logic [15:0] x, input logic [15:0] y, input logic c);
        logic [16:0] e;
        e = ref4(x, y, c);
        start4(x, y, c);
        wait4(tag);
        check({tag, "_sum"}, {16'd0, sum}, {16'd0, e[15:0]});
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, e[16]});
        take4(tag);
    endtask

    task automatic add1(input string tag, input logic [3:0] x, input logic [3:0] y, input logic c);
        logic [4:0] e;
        int lat = 0;
        e = {1'b0, x} + {1'b0, y} + {4'd0, c};
        a1 = x; b1 = y; cin1 = c; in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        a1 = 4'($urandom);
        while (!out_valid1 && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, 32'd1);
        check({tag, "_sum"}, {28'd0, sum1}, {28'd0, e[3:0]});
        check({tag, "_cout"}, {31'd0, cout1}, {31'd0, e[4]});
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        check({tag, "_idle"}, {31'd0, in_ready1}, 32'd1);
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic        rc;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        tick();
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        add4("t_1234", 16'h1234, 16'h4321, 1'b0);
        add4("t_ffff_1", 16'hFFFF, 16'h0001, 1'b0);
        add4("t_ffff_cin", 16'hFFFF, 16'h0000, 1'b1);
        add4("t_0f0f", 16'h0F0F, 16'h00F1, 1'b0);

        // Backpressure with a competing input that must be ignored
        start4(16'h1234, 16'h4321, 1'b0);
        wait4("bp");
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a = 16'hAAAA; b = 16'h1111; cin = 1'b1;
            check("bp_sum", {16'd0, sum}, 32'h5555);
            check("bp_cout", {31'd0, cout}, 32'd0);
            check("bp_ov", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
        end
        in_valid = 1'b0;
        check("bp_sum_end", {16'd0, sum}, 32'h5555);
        take4("bp");
        check("bp_no_restart", {31'd0, busy}, 32'd0);

        // Reset one cycle after acceptance
        start4(16'h1234, 16'h4321, 1'b0);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check("mid_rst_sum", {16'd0, sum}, 32'd0);
        check("mid_rst_cout", {31'd0, cout}, 32'd0);
        check("mid_rst_ov", {31'd0, out_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("mid_rst_no_ov", {31'd0, out_valid}, 32'd0);
            tick();
        end
        add4("post_rst_1p1", 16'h0001, 16'h0001, 1'b0);

        for (int i = 0; i < 25; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            add4("rand4", ra, rb, rc);
        end

        add1("n1_f_1", 4'hF, 4'h1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            add1("rand1", 4'($urandom), 4'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle wide adder that sits directly upstream of the team's 4-bit `ripple_carry` adder (ports `a`, `b`, `cin`, `sum`, `cout`).
- Accepts wide operands over a valid/ready handshake and slices them into nibbles, LSB first.
- Feeds one nibble per cycle into a single `ripple_carry` instance, registering the carry between cycles, and assembles the wide sum.
- Trades latency for area: one 4-bit adder serves any operand width.

Parameters:
- `N_NIBBLES`, default 4: number of 4-bit slices. Operand and sum width W = 4*`N_NIBBLES`. Legal range 1..16.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands present on `a`/`b`/`cin`.
- `in_ready`  out  1  block can accept operands.
- `a`  in  W  operand A.
- `b`  in  W  operand B.
- `cin`  in  1  carry into nibble 0.
- `out_valid`  out  1  `sum`/`cout` hold a completed result.
- `out_ready`  in  1  consumer takes the result.
- `sum`  out  W  registered result.
- `cout`  out  1  carry out of the top nibble.
- `busy`  out  1  high in ADD or DONE.

Behaviour:
- One clock; reset is synchronous and active-high. `rst` is sampled only on the rising edge of `clk`.
- Reset values:
  - state = IDLE, nibble index `idx` = 0, carry register = 0.
  - `sum` = 0, `cout` = 0, `out_valid` = 0, `busy` = 0.
  - `in_ready` = 0 while `rst` is high; `in_ready` = 1 in the first cycle after reset is released.
- States: IDLE, ADD, DONE.
- IDLE:
  - `in_ready` = 1, `busy` = 0.
  - On an edge with `in_valid` && `in_ready`: latch `a`, `b` into internal operand registers; carry register <= `cin`; `idx` <= 0; clear `sum` to 0; go to ADD.
  - Inputs are ignored when `in_valid` = 0.
- ADD:
  - `in_ready` = 0, `busy` = 1.
  - The `ripple_carry` instance receives `a_reg[4*idx+3:4*idx]`, `b_reg[4*idx+3:4*idx]` and the carry register. This path is combinational only; no register sits between the block and the adder.
  - Each edge: `sum[4*idx+3:4*idx]` <= adder sum; carry register <= adder cout; `idx` <= `idx`+1.
  - When `idx` == `N_NIBBLES`-1 at the edge: `cout` <= adder cout and go to DONE.
- DONE:
  - `out_valid` = 1, `busy` = 1, `in_ready` = 0.
  - `sum` and `cout` stay stable while `out_ready` = 0; hold indefinitely.
  - On an edge with `out_ready` = 1: `out_valid` <= 0 and go to IDLE.
- Latency: if operands are accepted on edge E, `out_valid` rises after edge E+`N_NIBBLES`.
- Throughput: with `out_ready` tied high, one result per `N_NIBBLES`+2 cycles.
- No overlap: a new input cannot be accepted in the same cycle a result is taken. `in_valid` is ignored in ADD and DONE; the upstream must hold its operands until `in_ready`.
- Arithmetic: {`cout`, `sum`} = `a` + `b` + `cin`, computed modulo 2^(W+1). No overflow flag; `cout` is the sole carry indication.
- Intermediate `sum` bits are visible during ADD but are only meaningful while `out_valid` = 1.
- Operand registers are unaffected by changes on `a`/`b` after acceptance.
- Reset mid-operation (ADD or DONE): on the next edge, return to IDLE with all reset values. Any pending result is discarded and no `out_valid` pulse is produced.
- `N_NIBBLES` = 1: ADD lasts exactly one cycle; behaviour is otherwise identical.

Test Plan:
- `N_NIBBLES`=4, `a`=0x1234, `b`=0x4321, `cin`=0, accepted on edge E -> `out_valid`=1 after E+4, `sum`=0x5555, `cout`=0; `in_ready`=0 from E+1 until `out_ready` is taken.
- `a`=0xFFFF, `b`=0x0001, `cin`=0 -> `sum`=0x0000, `cout`=1; checks carry propagation through all four nibble boundaries.
- `a`=0xFFFF, `b`=0x0000, `cin`=1 -> `sum`=0x0000, `cout`=1.
- `a`=0x0F0F, `b`=0x00F1, `cin`=0 -> `sum`=0x1000, `cout`=0.
- Backpressure: result 0x5555 ready with `out_ready`=0 for 5 cycles -> `sum`/`cout`/`out_valid` stable, `in_ready`=0, and a concurrent `in_valid` with new operands is ignored. Then `out_ready`=1 -> IDLE on the next edge, `in_ready`=1 the cycle after.
- Reset mid-ADD: assert `rst` one cycle after acceptance -> next edge `sum`=0, `cout`=0, `out_valid`=0, `in_ready`=0 while `rst` is high. Release `rst`, then run 0x0001+0x0001 -> `sum`=0x0002.
- `N_NIBBLES`=1: `a`=0xF, `b`=0x1, `cin`=0 -> `sum`=0x0, `cout`=1, `out_valid` one edge after acceptance.
